onewire_tx_arbiter: RTL

ONEWIRE_TX_ARBITER -- requirements
Module: onewire_tx_arbiter

---
 rtl/onewire_pkg.sv | 19 +
 rtl/onewire_tx_arbiter_if.sv | 32 +++
 rtl/onewire_rr_pick.sv | 30 +++
 rtl/onewire_tx_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared types and constants for the one-wire transmit arbiter:
// FSM state encoding, payload width and the grant-index width helper.
package onewire_pkg;

  localparam int ONEWIRE_DATA_W = 56;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  // Width of a requester index; never below one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onewire_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the one-wire transmit arbiter.
// slave = arbiter view, master = requesters plus transmitter view.
interface onewire_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import onewire_pkg::*;

  localparam int GW = grant_w(NUM_REQ);

  logic [NUM_REQ-1:0]                i_req;
  logic [NUM_REQ*ONEWIRE_DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]                o_ack;
  logic [NUM_REQ-1:0]                o_done;
  logic [NUM_REQ-1:0]                o_err;
  logic [ONEWIRE_DATA_W-1:0]         o_tx_data;
  logic                              o_tx_start;
  logic                              i_tx_busy;
  logic                              i_tx_done;
  logic                              o_busy;
  logic [GW-1:0]                     o_grant_id;

  modport slave (
    input  i_req, i_req_data, i_tx_busy, i_tx_done,
    output o_ack, o_done, o_err, o_tx_data, o_tx_start, o_busy, o_grant_id
  );

  modport master (
    output i_req, i_req_data, i_tx_busy, i_tx_done,
    input  o_ack, o_done, o_err, o_tx_data, o_tx_start, o_busy, o_grant_id
  );

endinterface

// File: rtl/onewire_rr_pick.sv
// Combinational round-robin picker: the first requester found searching upward
// from last_grant+1 (with wrap-around) wins.
module onewire_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic               valid,
  output logic [GW-1:0]      winner
);

  logic [GW-1:0] idx;

  // NOTE: every output of a combinational block gets a default first; a path that skips an assignment would infer a latch.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    // Scan from the farthest offset down to the nearest, so the nearest hit overwrites.
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = GW'((int'(last_grant) + off) % NUM_REQ);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/onewire_tx_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one one-wire transmitter.
// Optional watchdog: define ONEWIRE_ARB_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES.
module onewire_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 reset,
  onewire_tx_arbiter_if.slave bus
);
  import onewire_pkg::*;

  localparam int GW = grant_w(NUM_REQ);

  state_t                    state, state_nxt;
  logic                      pick, pick_valid, timeout, err_flag, tx_start;
  logic [GW-1:0]             pick_id, grant_id, last_grant;
  logic [NUM_REQ-1:0]        ack_q, pick_onehot, grant_onehot, done_vec;
  logic [ONEWIRE_DATA_W-1:0] tx_data, pick_data;

  onewire_rr_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) u_pick (
    .req        (bus.i_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_id)
  );

  // NOTE: clocked state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pick      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          pick      = 1'b1;
          state_nxt = ST_START;
        end
      end
      // A done pulse before busy was ever seen still completes the frame.
      ST_START: begin
        if (bus.i_tx_done || timeout) state_nxt = ST_RELEASE;
        else if (bus.i_tx_busy)       state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.i_tx_done || timeout) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pick_onehot          = '0;
    pick_onehot[pick_id] = 1'b1;
    grant_onehot           = '0;
    grant_onehot[grant_id] = 1'b1;
    pick_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_id == GW'(k)) pick_data = bus.i_req_data[k*ONEWIRE_DATA_W +: ONEWIRE_DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q      <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      ack_q    <= pick ? pick_onehot : '0;
      tx_start <= (state_nxt == ST_START);
      if (pick) begin
        tx_data  <= pick_data;
        grant_id <= pick_id;
      end
      if (state == ST_RELEASE) last_grant <= grant_id;
    end
  end

`ifdef ONEWIRE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0]      wd_cnt;
  logic [NUM_REQ-1:0] err_vec;

  always_ff @(posedge clk) begin
    if (reset)                                            wd_cnt <= '0;
    else if (pick)                                        wd_cnt <= '0;
    else if (state == ST_START || state == ST_WAIT_DONE) wd_cnt <= wd_cnt + 1'b1;
  end

  // Fires on the edge where the count reaches the limit: RELEASE lands TIMEOUT_CYCLES+1 cycles after the pick.
  assign timeout = (state == ST_START || state == ST_WAIT_DONE) &&
                   (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  // A done pulse coinciding with the timeout is recorded as a success.
  always_ff @(posedge clk) begin
    if (reset)                                               err_flag <= 1'b0;
    else if (state != ST_RELEASE && state_nxt == ST_RELEASE) err_flag <= ~bus.i_tx_done;
  end

  assign err_vec   = (state == ST_RELEASE && err_flag) ? grant_onehot : '0;
  assign bus.o_err = err_vec;
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign err_flag       = 1'b0;
  assign bus.o_err      = '0;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  assign done_vec = (state == ST_RELEASE && !err_flag) ? grant_onehot : '0;

  assign bus.o_ack      = ack_q;
  assign bus.o_done     = done_vec;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_start = tx_start;
  assign bus.o_busy     = (state != ST_IDLE);
  assign bus.o_grant_id = grant_id;

endmodule
